// File: rtl/spram_mc.sv
// Multi-channel single-port RAM controller: round-robin arbitration with
// per-channel burst lock, one access per cycle, registered read data.
module spram_mc #(
  parameter int ASZ = 17,
  parameter int DSZ = 8,
  parameter int NCH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NCH-1:0]     req,
  input  logic [NCH-1:0]     we,
  input  logic [NCH-1:0]     lk,
  input  logic [NCH*ASZ-1:0] ai,
  input  logic [NCH*DSZ-1:0] vi,
  output logic [NCH-1:0]     gnt,
  output logic [DSZ-1:0]     vo,
  output logic [NCH-1:0]     vld
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    rr_q, rr_d;
  logic [CW-1:0]    own_q, own_d;
  logic [DSZ-1:0]   vo_q, vo_d;
  logic [NCH-1:0]   vld_q, vld_d;

  logic [DSZ-1:0]   mem [0:(1<<ASZ)-1];

  logic             hold_s;
  logic             hit_s;
  logic [CW-1:0]    start_s;
  logic [CW-1:0]    win_s;
  logic [CW-1:0]    cand_s;
  logic [NCH-1:0]   gnt_s;
  logic             wr_s;
  logic             rd_s;
  logic [ASZ-1:0]   addr_s;
  logic [DSZ-1:0]   wdat_s;

  function automatic logic [CW-1:0] inc_wrap(input logic [CW-1:0] x);
    inc_wrap = (int'(x) >= NCH - 1) ? {CW{1'b0}} : x + 1'b1;
  endfunction

  function automatic logic [CW-1:0] rot(input logic [CW-1:0] s, input int i);
    int t;
    t = int'(s) + i;
    rot = (t >= NCH) ? CW'(t - NCH) : CW'(t);
  endfunction

  // Grant selection: a live lock pins the owner, otherwise the lowest
  // rotated index wins, so scan from the far end and let later hits override.
  always_comb begin
    hold_s  = (state_q == ST_LOCKED) && req[own_q] && lk[own_q];
    start_s = (state_q == ST_LOCKED) ? inc_wrap(own_q) : rr_q;
    hit_s   = 1'b0;
    win_s   = {CW{1'b0}};
    cand_s  = {CW{1'b0}};
    for (int i = NCH - 1; i >= 0; i--) begin
      cand_s = rot(start_s, i);
      win_s  = req[cand_s] ? cand_s : win_s;
      hit_s  = hit_s | req[cand_s];
    end
    win_s = hold_s ? own_q : win_s;
    hit_s = hold_s | hit_s;
    gnt_s = {NCH{1'b0}};
    gnt_s[win_s] = rst_n & hit_s;
  end

  // Datapath selects for the winning channel.
  always_comb begin
    wr_s   = (|gnt_s) & we[win_s];
    rd_s   = (|gnt_s) & ~we[win_s];
    addr_s = ai[int'(win_s)*ASZ +: ASZ];
    wdat_s = vi[int'(win_s)*DSZ +: DSZ];
    vo_d   = rd_s ? mem[addr_s] : vo_q;
    vld_d  = rd_s ? gnt_s : {NCH{1'b0}};
  end

  // Arbitration state; leaving a lock restarts the search just past the owner.
  always_comb begin
    if (hold_s) begin
      state_d = ST_LOCKED;
      own_d   = own_q;
      rr_d    = rr_q;
    end else if (hit_s && lk[win_s]) begin
      state_d = ST_LOCKED;
      own_d   = win_s;
      rr_d    = start_s;
    end else if (hit_s) begin
      state_d = ST_ARB;
      own_d   = own_q;
      rr_d    = inc_wrap(win_s);
    end else begin
      state_d = ST_ARB;
      own_d   = own_q;
      rr_d    = start_s;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ARB;
      rr_q    <= {CW{1'b0}};
      own_q   <= {CW{1'b0}};
      vo_q    <= {DSZ{1'b0}};
      vld_q   <= {NCH{1'b0}};
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      own_q   <= own_d;
      vo_q    <= vo_d;
      vld_q   <= vld_d;
    end
  end

  // Storage array, deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem[addr_s] <= wdat_s;
    end
  end

  assign gnt = gnt_s;
  assign vo  = vo_q;
  assign vld = vld_q;

  spram_mc_chk #(.NCH(NCH)) u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt_s),
    .vld   (vld_q)
  );

endmodule

// Protocol properties of the controller outputs.
module spram_mc_chk #(
  parameter int NCH = 2
) (
  input logic           clk,
  input logic           rst_n,
  input logic [NCH-1:0] req,
  input logic [NCH-1:0] gnt,
  input logic [NCH-1:0] vld
);

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt))
    else $error("gnt not one-hot");
  a_gnt_req: assert property (@(posedge clk) disable iff (!rst_n) ((gnt & ~req) == {NCH{1'b0}}))
    else $error("gnt without req");
  a_vld_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(vld))
    else $error("vld not one-hot");

endmodule

// File: tb/tb_spram_mc.sv
// Directed self-checking bench for spram_mc with two channels, 17-bit
// addresses and 8-bit data.
module tb_spram_mc;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req, we, lk;
  logic [33:0] ai;
  logic [15:0] vi;
  logic [1:0]  gnt;
  logic [7:0]  vo;
  logic [1:0]  vld;
  int          total = 0;
  int          bad   = 0;

  spram_mc #(.ASZ(17), .DSZ(8), .NCH(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .lk(lk),
    .ai(ai), .vi(vi), .gnt(gnt), .vo(vo), .vld(vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    req = 2'b00; we = 2'b00; lk = 2'b00;
  endtask

  task automatic set_ch(input int k, input logic r, input logic w, input logic l,
                        input logic [16:0] a, input logic [7:0] v);
    req[k] = r; we[k] = w; lk[k] = l;
    ai[k*17 +: 17] = a;
    vi[k*8 +: 8]   = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 2'b11; we = 2'b00; lk = 2'b00; ai = '0; vi = '0;
    #3;
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
    total++; if (vo !== 8'h00) begin bad++; $display("FAIL reset_vo got=%h exp=00", vo); end
    total++; if (vld !== 2'b00) begin bad++; $display("FAIL reset_vld got=%b exp=00", vld); end
    tick();
    total++; if (vld !== 2'b00) begin bad++; $display("FAIL reset_vld_edge got=%b exp=00", vld); end
    idle();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    for (int i = 0; i <= 16; i++) begin
      idle(); set_ch(0, 1'b1, 1'b1, 1'b0, i[16:0], i[7:0]);
      #2;
      total++; if (gnt !== 2'b01) begin bad++; $display("FAIL wr_gnt i=%0d got=%b exp=01", i, gnt); end
      tick();
      total++; if (vld !== 2'b00) begin bad++; $display("FAIL wr_vld i=%0d got=%b exp=00", i, vld); end
    end
    for (int i = 0; i <= 16; i++) begin
      idle(); set_ch(0, 1'b1, 1'b0, 1'b0, i[16:0], 8'h00);
      #2;
      total++; if (gnt !== 2'b01) begin bad++; $display("FAIL rd_gnt i=%0d got=%b exp=01", i, gnt); end
      tick();
      total++; if (vo !== i[7:0]) begin bad++; $display("FAIL rd_vo i=%0d got=%h exp=%h", i, vo, i[7:0]); end
      total++; if (vld !== 2'b01) begin bad++; $display("FAIL rd_vld i=%0d got=%b exp=01", i, vld); end
    end
    idle();
    #2;
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL idle_gnt got=%b exp=00", gnt); end
    tick();
    total++; if (vld !== 2'b00) begin bad++; $display("FAIL idle_vld got=%b exp=00", vld); end
    total++; if (vo !== 8'h10) begin bad++; $display("FAIL idle_vo_hold got=%h exp=10", vo); end
  endtask

  task automatic test_contention();
    logic [1:0] exp_g [4];
    logic [7:0] exp_v [4];
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_v = '{8'h05, 8'h06, 8'h05, 8'h06};
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle();
    set_ch(0, 1'b1, 1'b0, 1'b0, 17'h00005, 8'h00);
    set_ch(1, 1'b1, 1'b0, 1'b0, 17'h00006, 8'h00);
    for (int c = 0; c < 4; c++) begin
      #2;
      total++; if (gnt !== exp_g[c]) begin bad++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, gnt, exp_g[c]); end
      tick();
      total++; if (vld !== exp_g[c]) begin bad++; $display("FAIL rr_vld c=%0d got=%b exp=%b", c, vld, exp_g[c]); end
      total++; if (vo !== exp_v[c]) begin bad++; $display("FAIL rr_vo c=%0d got=%h exp=%h", c, vo, exp_v[c]); end
    end
  endtask

  task automatic test_lock();
    idle(); set_ch(0, 1'b1, 1'b0, 1'b0, 17'h00008, 8'h00);
    #2;
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL lk_pre_gnt got=%b exp=01", gnt); end
    tick();
    for (int c = 0; c < 5; c++) begin
      set_ch(1, 1'b1, 1'b0, 1'b1, 17'(9 + c), 8'h00);
      #2;
      total++; if (gnt !== 2'b10) begin bad++; $display("FAIL lk_gnt c=%0d got=%b exp=10", c, gnt); end
      tick();
      total++; if (vo !== 8'(9 + c)) begin bad++; $display("FAIL lk_vo c=%0d got=%h exp=%h", c, vo, 8'(9 + c)); end
      total++; if (vld !== 2'b10) begin bad++; $display("FAIL lk_vld c=%0d got=%b exp=10", c, vld); end
    end
    set_ch(1, 1'b0, 1'b0, 1'b0, 17'h00000, 8'h00);
    #2;
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL lk_release_gnt got=%b exp=01", gnt); end
    tick();
    total++; if (vo !== 8'h08) begin bad++; $display("FAIL lk_release_vo got=%h exp=08", vo); end
    total++; if (vld !== 2'b01) begin bad++; $display("FAIL lk_release_vld got=%b exp=01", vld); end
    // Lock taken alone, then lk dropped while req stays: ch0 must win that cycle.
    idle(); set_ch(1, 1'b1, 1'b0, 1'b1, 17'h0000E, 8'h00);
    #2;
    total++; if (gnt !== 2'b10) begin bad++; $display("FAIL lk2_gnt got=%b exp=10", gnt); end
    tick();
    set_ch(0, 1'b1, 1'b0, 1'b0, 17'h0000F, 8'h00);
    set_ch(1, 1'b1, 1'b0, 1'b0, 17'h00010, 8'h00);
    #2;
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL lk2_exit_gnt got=%b exp=01", gnt); end
    tick();
    total++; if (vo !== 8'h0F) begin bad++; $display("FAIL lk2_exit_vo got=%h exp=0f", vo); end
  endtask

  task automatic test_boundary();
    idle(); set_ch(1, 1'b1, 1'b1, 1'b0, 17'h1FFFF, 8'hA5);
    #2;
    total++; if (gnt !== 2'b10) begin bad++; $display("FAIL bd_wr_gnt got=%b exp=10", gnt); end
    tick();
    total++; if (vld !== 2'b00) begin bad++; $display("FAIL bd_wr_vld got=%b exp=00", vld); end
    idle(); set_ch(1, 1'b1, 1'b1, 1'b0, 17'h00000, 8'h5A);
    tick();
    idle(); set_ch(0, 1'b1, 1'b0, 1'b0, 17'h1FFFF, 8'h00);
    tick();
    total++; if (vo !== 8'hA5) begin bad++; $display("FAIL bd_top_vo got=%h exp=a5", vo); end
    idle(); set_ch(0, 1'b1, 1'b0, 1'b0, 17'h00000, 8'h00);
    tick();
    total++; if (vo !== 8'h5A) begin bad++; $display("FAIL bd_zero_vo got=%h exp=5a", vo); end
  endtask

  task automatic test_raw();
    idle(); set_ch(0, 1'b1, 1'b1, 1'b0, 17'h00100, 8'h3C);
    tick();
    idle(); set_ch(0, 1'b1, 1'b0, 1'b0, 17'h00100, 8'h00);
    tick();
    total++; if (vo !== 8'h3C) begin bad++; $display("FAIL raw_vo got=%h exp=3c", vo); end
    total++; if (vld !== 2'b01) begin bad++; $display("FAIL raw_vld got=%b exp=01", vld); end
  endtask

  task automatic test_reset_mid();
    idle(); set_ch(1, 1'b1, 1'b0, 1'b0, 17'h1FFFF, 8'h00);
    #2;
    total++; if (gnt !== 2'b10) begin bad++; $display("FAIL rm_gnt got=%b exp=10", gnt); end
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (vo !== 8'h00) begin bad++; $display("FAIL rm_vo got=%h exp=00", vo); end
    total++; if (vld !== 2'b00) begin bad++; $display("FAIL rm_vld got=%b exp=00", vld); end
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL rm_gnt_rst got=%b exp=00", gnt); end
    tick();
    total++; if (vo !== 8'h00) begin bad++; $display("FAIL rm_vo_edge got=%h exp=00", vo); end
    rst_n = 1'b1;
    idle();
    set_ch(0, 1'b1, 1'b0, 1'b0, 17'h1FFFF, 8'h00);
    set_ch(1, 1'b1, 1'b0, 1'b0, 17'h00000, 8'h00);
    #2;
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL rm_first_gnt got=%b exp=01", gnt); end
    tick();
    total++; if (vo !== 8'hA5) begin bad++; $display("FAIL rm_first_vo got=%h exp=a5", vo); end
    total++; if (vld !== 2'b01) begin bad++; $display("FAIL rm_first_vld got=%b exp=01", vld); end
    #2;
    total++; if (gnt !== 2'b10) begin bad++; $display("FAIL rm_second_gnt got=%b exp=10", gnt); end
    tick();
    total++; if (vo !== 8'h5A) begin bad++; $display("FAIL rm_second_vo got=%h exp=5a", vo); end
    idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_lock();
    test_boundary();
    test_raw();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
